fetch_unit: RTL

//  Instruction fetch stage; producer of the 32-bit instruction word consumed by decode.

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_unit_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Contents: fetch FSM state encoding, PC increment, FIFO entry layout,
// and a word-alignment helper.
package fetch_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    FETCH_ST_FETCH   = 2'd0,
    FETCH_ST_DISCARD = 2'd1,
    FETCH_ST_HALT    = 2'd2
  } fetch_state_e;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Clear the byte-offset bits of an address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO holding {pc, instr} entries between fetch and decode.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, wdata_i   write an entry (ignored when full unless popping)
//   pop_i             remove the head entry (ignored when empty)
//   flush_i           drop all entries; overrides push/pop
//   rdata_o           head entry
//   count_o, empty_o  occupancy
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             wdata_i,
  output fetch_entry_t             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is allowed only when the head leaves the same cycle.
  assign do_push = push_i && (!full || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array, no reset needed: contents are only observed when count_q != 0.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one-outstanding word requests
// to instruction memory, buffers returned words with their PC and presents
// them to decode with valid/ready. Taken branches flush and redirect.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect halts
// fetch and raises a sticky fault; otherwise the target is word-aligned).
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   imem_req_o/imem_addr_o         fetch request, word address
//   imem_ack_i/imem_rdata_i        memory response
//   branch_taken_i/branch_target_i redirect from execute
//   instr_o/pc_o/valid_o/ready_i   decode interface
//   fetch_fault_o                  misaligned redirect fault
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        fetch_fault_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q;
  logic [31:0]   pc_q;
  logic [31:0]   redir_q;
  logic          req_q;
  fetch_entry_t  hold_q;

  fetch_entry_t  head;
  fetch_entry_t  wdata_c;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt_c;
  logic          empty;
  logic          ack_fire_c;
  logic          push_c;
  logic          pop_c;
  logic [31:0]   tgt_c;

  assign ack_fire_c  = req_q && imem_ack_i;
  assign push_c      = ack_fire_c && (state_q == FETCH_ST_FETCH) && !branch_taken_i;
  assign pop_c       = valid_o && ready_i;
  assign count_nxt_c = count + CW'(push_c) - CW'(pop_c);
  assign tgt_c       = word_align(branch_target_i);
  assign wdata_c     = '{pc: pc_q, instr: imem_rdata_i};

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;
  assign valid_o     = !empty;
  // When the buffer is empty the last presented entry stays on the outputs.
  assign instr_o     = valid_o ? head.instr : hold_q.instr;
  assign pc_o        = valid_o ? head.pc    : hold_q.pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;
  logic misalign_c;
  assign misalign_c    = (branch_target_i[1:0] != 2'b00);
  assign fetch_fault_o = fault_q;
`else
  assign fetch_fault_o = 1'b0;
`endif

  fetch_unit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .flush_i (branch_taken_i),
    .wdata_i (wdata_c),
    .rdata_o (head),
    .count_o (count),
    .empty_o (empty)
  );

  // PC, request and redirect state machine.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH_ST_FETCH;
      pc_q    <= RESET_PC;
      redir_q <= RESET_PC;
      req_q   <= 1'b0;
      hold_q  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      if (valid_o) hold_q <= head;

      unique case (state_q)
        FETCH_ST_FETCH: begin
          if (branch_taken_i) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misalign_c) begin
              // Request may still be in flight: keep it up until its ack.
              state_q   <= FETCH_ST_HALT;
              req_q     <= req_q && !imem_ack_i;
              fault_q   <= 1'b1;
              hold_q.pc <= branch_target_i;
            end else
`endif
            if (req_q && !imem_ack_i) begin
              // Address must stay stable until the stale request is acked.
              state_q <= FETCH_ST_DISCARD;
              redir_q <= tgt_c;
            end else begin
              pc_q  <= tgt_c;
              req_q <= 1'b1;
            end
          end else begin
            if (ack_fire_c) pc_q <= pc_q + PC_INC;
            req_q <= (count_nxt_c < CW'(FIFO_DEPTH));
          end
        end

        FETCH_ST_DISCARD: begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (branch_taken_i && misalign_c) begin
            state_q   <= FETCH_ST_HALT;
            req_q     <= !imem_ack_i;
            fault_q   <= 1'b1;
            hold_q.pc <= branch_target_i;
          end else
`endif
          if (imem_ack_i) begin
            // Stale data is dropped; the newest redirect target wins.
            state_q <= FETCH_ST_FETCH;
            pc_q    <= branch_taken_i ? tgt_c : redir_q;
            req_q   <= 1'b1;
          end else if (branch_taken_i) begin
            redir_q <= tgt_c;
          end
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        FETCH_ST_HALT: begin
          req_q <= req_q && !imem_ack_i;
        end
`endif

        default: begin
          state_q <= FETCH_ST_FETCH;
        end
      endcase
    end
  end

endmodule
